// File: rtl/key_expansion_pkg.sv
// key_expansion_pkg: shared AES-128 key schedule tables, round count and FSM states
package key_expansion_pkg;
  typedef enum logic {IDLE, EMIT} state_t;
  localparam logic [3:0] NUM_ROUNDS = 4'd10;
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box lookup
module aes_sbox
  import key_expansion_pkg::*;
(
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);
  assign o_out = SBOX[i_in];
endmodule

// File: rtl/key_expansion.sv
// key_expansion: AES-128 key schedule presenting round keys 0..10 over a valid/ready handshake
module key_expansion
  import key_expansion_pkg::*;
#(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [vecSize-1:0][regSize-1:0]  cipher_key,
  input  logic                             rk_ready,
  output logic [vecSize-1:0][regSize-1:0]  round_key,
  output logic [3:0]                       round_idx,
  output logic                             rk_valid,
  output logic                             busy,
  output logic                             done
);
  state_t                          r_state;
  logic [vecSize-1:0][regSize-1:0] r_key;
  logic [3:0]                      r_idx;
  logic                            r_valid, r_busy, r_done;
  logic [31:0]                     w_rot, w_sub, w_t, w_n0, w_n1, w_n2, w_n3;
  assign w_rot = {r_key[3][23:0], r_key[3][31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sb
    aes_sbox u_sbox (.i_in(w_rot[8*i +: 8]), .o_out(w_sub[8*i +: 8]));
  end
  // RCON is padded past round 10 so the unused lookup at idx 10 stays in range
  assign w_t  = w_sub ^ {RCON[r_idx + 4'd1], 24'h0};
  assign w_n0 = r_key[0] ^ w_t;
  assign w_n1 = r_key[1] ^ w_n0;
  assign w_n2 = r_key[2] ^ w_n1;
  assign w_n3 = r_key[3] ^ w_n2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_state <= EMIT;
          r_key   <= cipher_key;
          r_idx   <= '0;
          r_valid <= 1'b1;
          r_busy  <= 1'b1;
        end
      end else if (r_valid && rk_ready) begin
        if (r_idx == NUM_ROUNDS) begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_key <= {w_n3, w_n2, w_n1, w_n0};
          r_idx <= r_idx + 4'd1;
        end
      end
    end
  end
  assign round_key = r_key;
  assign round_idx = r_idx;
  assign rk_valid  = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;
endmodule
